ahb_resp_mux: RTL and testbench
===============================

# ahb_resp_mux

Return-path (slave-to-master) multiplexer for the AHB-Lite fabric, with an integrated default slave. It registers the slave selects produced by the address decoder during the address phase and routes the selected slave's HRDATA, HREADYOUT and HRESP to the master during the data phase. Data phases decoded to the default region receive the protocol two-cycle ERROR response. It sits between the decoder/slave outputs and the single bus master.

## Interface
Parameters:
- DATA_WIDTH, 32, width of read data.
- TIMEOUT_CYCLES, 16, wait-state limit for the SRAM slave. Used only when AHB_MUX_TIMEOUT_EN is defined. Legal range is 2..255.

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HTRANS  in  2  master transfer type, address phase.
- HSEL_SRAM  in  1  decoder select for SRAM, address phase.
- HSEL_DEFAULT  in  1  decoder select for default region, address phase.
- HRDATA_SRAM  in  DATA_WIDTH  SRAM read data.
- HREADYOUT_SRAM  in  1  SRAM ready.
- HRESP_SRAM  in  1  SRAM response (0 = OKAY, 1 = ERROR).
- HRDATA  out  DATA_WIDTH  read data to master.
- HREADY  out  1  transfer-done to master. Also fed back to all slaves as HREADY.
- HRESP  out  1  response to master.
- HTIMEOUT  out  1  one-cycle pulse when the watchdog fires. Present only with AHB_MUX_TIMEOUT_EN.

## Operation
- Data-phase select register `dp_sel`:
  - Values: NONE, SRAM or DEFAULT.
  - Loaded from {HSEL_SRAM, HSEL_DEFAULT} on every rising edge where HREADY = 1.
  - Held while HREADY = 0.
- Both selects high at the same time is illegal. If it occurs, SRAM wins.
- dp_sel = NONE: HREADY = 1, HRESP = 0, HRDATA = 0. This is a zero-wait OKAY for IDLE cycles and unselected cycles.
- dp_sel = SRAM: HRDATA, HREADY and HRESP pass straight through from the SRAM combinationally.
- dp_sel = DEFAULT: outputs are driven by the default-slave FSM.
  - States: DS_IDLE, DS_ERR1, DS_ERR2.
  - DS_IDLE → DS_ERR1 on an edge where HREADY = 1 and HSEL_DEFAULT = 1 (an accepted address phase).
  - DS_ERR1 → DS_ERR2 unconditionally. Outputs in DS_ERR1: HREADY = 0, HRESP = 1.
  - DS_ERR2 → DS_ERR1 if HSEL_DEFAULT = 1 in that same cycle (back-to-back default accesses), otherwise → DS_IDLE. Outputs in DS_ERR2: HREADY = 1, HRESP = 1.
  - HRDATA = 0 in every default-slave state.
- HTRANS is used only for qualification. BUSY or IDLE with a stale select is treated as NONE, which matches the decoder's NONSEQ/SEQ gating.
- Reset values:
  - dp_sel = NONE, FSM = DS_IDLE, watchdog counter = 0.
  - HREADY = 1, HRESP = 0, HRDATA = 0, HTIMEOUT = 0.
- Reset asserted mid-transfer (including during DS_ERR1 or an SRAM wait) aborts the transfer. The block returns to reset values on the next edge.

## Timing
- Address phase at edge N with HREADY = 1 → data-phase outputs valid in cycle N+1.
- Pass-through adds no latency.
- A default-region access takes exactly 2 data-phase cycles: the ERROR response is 1 wait cycle followed by the completion cycle.
- dp_sel and the FSM change only on rising edges while HRESET = 0.
- Write and read are handled identically. HWRITE is not needed.

## Configuration
- AHB_MUX_TIMEOUT_EN defined:
  - An 8-bit counter increments each cycle while dp_sel = SRAM and HREADYOUT_SRAM = 0.
  - The counter clears when HREADYOUT_SRAM = 1 or dp_sel ≠ SRAM.
  - When the count reaches TIMEOUT_CYCLES, the mux overrides the SRAM with the same two-cycle ERROR sequence via states TO_ERR1/TO_ERR2. It pulses HTIMEOUT for 1 cycle in TO_ERR1.
  - The SRAM's own outputs are ignored until dp_sel reloads.
- AHB_MUX_TIMEOUT_EN undefined: no counter, no HTIMEOUT port, and SRAM waits are unbounded.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS constants (IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11).
  - HRESP constants (OKAY = 0, ERROR = 1).
  - The dp_sel enum.
  - The FSM state enum, including the TO_* states.
- Sub-module ahb_default_slave contains the DS_* FSM. Its outputs are HREADYOUT and HRESP. The mux instantiates it and selects its outputs.

## Test plan
- Reset: hold HRESET for 2 cycles mid SRAM wait → HREADY = 1, HRESP = 0, HRDATA = 0 on the first cycle after release.
- SRAM read: NONSEQ with HSEL_SRAM, then HRDATA_SRAM = 32'hDEAD_BEEF with HREADYOUT_SRAM = 1 → HRDATA = 32'hDEAD_BEEF, HRESP = 0 in the next cycle.
- SRAM with 3 wait states: HREADYOUT_SRAM low for 3 cycles → HREADY low for 3 cycles. A new address presented during the waits is not captured until HREADY = 1.
- Default access: NONSEQ to 32'h0001_0000 → HREADY/HRESP = 0/1 then 1/1. Back-to-back default accesses → the sequence 0/1, 1/1, 0/1, 1/1.
- IDLE cycles between transfers → HREADY = 1, HRESP = 0 with dp_sel = NONE.
- AHB_MUX_TIMEOUT_EN with TIMEOUT_CYCLES = 4: SRAM never ready → HTIMEOUT pulses once, the ERROR pair appears, and the following IDLE returns HREADY = 1.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the enums for the response mux.
// Build option: AHB_MUX_TIMEOUT_EN enables the SRAM wait-state watchdog.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DP_NONE,
        DP_SRAM,
        DP_DEFAULT
    } dp_sel_e;

    typedef enum logic [2:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2,
        TO_ERR1,
        TO_ERR2
    } ahb_state_e;

    // Only NONSEQ/SEQ carry a real transfer; IDLE/BUSY are zero-wait OKAY.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_resp_mux_if.sv
// Bus bundle between decoder/SRAM, the response mux and the master.
// Build option: AHB_MUX_TIMEOUT_EN adds the HTIMEOUT pulse.
interface ahb_resp_mux_if #(
    parameter int DATA_WIDTH = 32
);

    logic [1:0]            HTRANS;
    logic                  HSEL_SRAM;
    logic                  HSEL_DEFAULT;
    logic [DATA_WIDTH-1:0] HRDATA_SRAM;
    logic                  HREADYOUT_SRAM;
    logic                  HRESP_SRAM;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;
`ifdef AHB_MUX_TIMEOUT_EN
    logic                  HTIMEOUT;
`endif

    modport slave (
        input  HTRANS,
        input  HSEL_SRAM,
        input  HSEL_DEFAULT,
        input  HRDATA_SRAM,
        input  HREADYOUT_SRAM,
        input  HRESP_SRAM,
`ifdef AHB_MUX_TIMEOUT_EN
        output HTIMEOUT,
`endif
        output HRDATA,
        output HREADY,
        output HRESP
    );

    modport master (
        output HTRANS,
        output HSEL_SRAM,
        output HSEL_DEFAULT,
        output HRDATA_SRAM,
        output HREADYOUT_SRAM,
        output HRESP_SRAM,
`ifdef AHB_MUX_TIMEOUT_EN
        input  HTIMEOUT,
`endif
        input  HRDATA,
        input  HREADY,
        input  HRESP
    );

endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: answers every accepted access with the two-cycle ERROR.
// Outputs are registered alongside the state.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic hready,
    input  logic sel,
    output logic hreadyout,
    output logic hresp
);

    ahb_state_e state;

    // ERROR sequence FSM; ERR2 is a completion cycle so it can accept again.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DS_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
        end else begin
            unique case (state)
                DS_IDLE: begin
                    if (hready && sel) begin
                        state     <= DS_ERR1;
                        hreadyout <= 1'b0;
                        hresp     <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state     <= DS_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    if (sel) begin
                        state     <= DS_ERR1;
                        hreadyout <= 1'b0;
                        hresp     <= HRESP_ERROR;
                    end else begin
                        state     <= DS_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= HRESP_OKAY;
                    end
                end
                default: begin
                    state     <= DS_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite return-path mux with integrated default slave.
// Build option: AHB_MUX_TIMEOUT_EN adds the SRAM wait-state watchdog.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          HCLK,
    input logic          HRESET,
    ahb_resp_mux_if.slave bus
);

    logic                  active;
    logic                  sel_sram;
    logic                  sel_dflt;
    logic                  ds_ready;
    logic                  ds_resp;
    dp_sel_e               dp_sel;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;
    logic                  resp;

    // SRAM wins if the decoder ever raises both selects.
    assign active   = trans_active(bus.HTRANS);
    assign sel_sram = active & bus.HSEL_SRAM;
    assign sel_dflt = active & bus.HSEL_DEFAULT & ~bus.HSEL_SRAM;

    // Capture the address-phase select; hold it across wait states.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_sel <= DP_NONE;
        end else if (bus.HREADY) begin
            unique case (1'b1)
                sel_sram: dp_sel <= DP_SRAM;
                sel_dflt: dp_sel <= DP_DEFAULT;
                default:  dp_sel <= DP_NONE;
            endcase
        end
    end

    ahb_default_slave u_dflt (
        .clk       (HCLK),
        .rst       (HRESET),
        .hready    (bus.HREADY),
        .sel       (sel_dflt),
        .hreadyout (ds_ready),
        .hresp     (ds_resp)
    );

`ifdef AHB_MUX_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_cnt;
    ahb_state_e to_state;

    // Watchdog: after TIMEOUT_CYCLES SRAM waits, take over with ERROR.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            to_cnt   <= 8'd0;
            to_state <= DS_IDLE;
        end else begin
            unique case (to_state)
                TO_ERR1: begin
                    to_cnt   <= 8'd0;
                    to_state <= TO_ERR2;
                end
                TO_ERR2: begin
                    to_cnt   <= 8'd0;
                    to_state <= DS_IDLE;
                end
                default: begin
                    if (dp_sel == DP_SRAM && !bus.HREADYOUT_SRAM) begin
                        if (to_cnt == TO_LAST) begin
                            to_cnt   <= 8'd0;
                            to_state <= TO_ERR1;
                        end else begin
                            to_cnt <= to_cnt + 8'd1;
                        end
                    end else begin
                        to_cnt <= 8'd0;
                    end
                end
            endcase
        end
    end

    assign bus.HTIMEOUT = (to_state == TO_ERR1);
`endif

    // Route the data-phase slave back to the master.
    always_comb begin
        rdata = '0;
        ready = 1'b1;
        resp  = HRESP_OKAY;
        unique case (dp_sel)
            DP_SRAM: begin
                rdata = bus.HRDATA_SRAM;
                ready = bus.HREADYOUT_SRAM;
                resp  = bus.HRESP_SRAM;
            end
            DP_DEFAULT: begin
                ready = ds_ready;
                resp  = ds_resp;
            end
            default: begin
            end
        endcase
`ifdef AHB_MUX_TIMEOUT_EN
        if (to_state == TO_ERR1) begin
            rdata = '0;
            ready = 1'b0;
            resp  = HRESP_ERROR;
        end else if (to_state == TO_ERR2) begin
            rdata = '0;
            ready = 1'b1;
            resp  = HRESP_ERROR;
        end
`endif
    end

    assign bus.HRDATA = rdata;
    assign bus.HREADY = ready;
    assign bus.HRESP  = resp;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux with a queue-based scoreboard.
// Build option: AHB_MUX_TIMEOUT_EN also runs the watchdog vectors.
module tb_ahb_resp_mux;

    localparam logic [1:0] TI = 2'b00;
    localparam logic [1:0] TB = 2'b01;
    localparam logic [1:0] TN = 2'b10;
    localparam logic [1:0] TS = 2'b11;

    typedef struct {
        string       name;
        logic        rdy;
        logic        rsp;
        logic [31:0] dat;
        logic        to;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t q[$];

    ahb_resp_mux_if #(.DATA_WIDTH(32)) bus ();

    ahb_resp_mux #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic v(input string nm, input logic r, input logic [1:0] tr,
                     input logic ss, input logic sd, input logic [31:0] rd,
                     input logic ry, input logic rp, input logic chk,
                     input logic er, input logic es, input logic [31:0] ed,
                     input logic et);
        exp_t e;
        @(posedge clk);
        #1;
        rst                = r;
        bus.HTRANS         = tr;
        bus.HSEL_SRAM      = ss;
        bus.HSEL_DEFAULT   = sd;
        bus.HRDATA_SRAM    = rd;
        bus.HREADYOUT_SRAM = ry;
        bus.HRESP_SRAM     = rp;
        if (chk) begin
            e.name = nm;
            e.rdy  = er;
            e.rsp  = es;
            e.dat  = ed;
            e.to   = et;
            q.push_back(e);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic got_to;
        if (q.size() > 0) begin
            e = q.pop_front();
`ifdef AHB_MUX_TIMEOUT_EN
            got_to = bus.HTIMEOUT;
`else
            got_to = 1'b0;
`endif
            checks++;
            if (bus.HREADY !== e.rdy || bus.HRESP !== e.rsp ||
                bus.HRDATA !== e.dat || got_to !== e.to) begin
                errors++;
                $display("FAIL %s: got rdy=%b rsp=%b dat=%h to=%b want rdy=%b rsp=%b dat=%h to=%b",
                         e.name, bus.HREADY, bus.HRESP, bus.HRDATA, got_to,
                         e.rdy, e.rsp, e.dat, e.to);
            end
        end
    end

    initial begin
        clk                = 1'b0;
        rst                = 1'b1;
        checks             = 0;
        errors             = 0;
        bus.HTRANS         = TI;
        bus.HSEL_SRAM      = 1'b0;
        bus.HSEL_DEFAULT   = 1'b0;
        bus.HRDATA_SRAM    = '0;
        bus.HREADYOUT_SRAM = 1'b1;
        bus.HRESP_SRAM     = 1'b0;

        //    name        rst tr ss sd rdata         ry rp chk rdy rsp dat           to
        v("rst0",        1, TI, 0, 0, 32'h0,        1, 0, 0,  1,  0,  32'h0,        0);
        v("rst1",        1, TI, 0, 0, 32'h0,        1, 0, 0,  1,  0,  32'h0,        0);
        v("reset",       0, TI, 0, 0, 32'h0,        1, 0, 1,  1,  0,  32'h0,        0);
        v("addr_none",   0, TN, 1, 0, 32'h1234,     1, 0, 1,  1,  0,  32'h0,        0);
        v("sram_rd",     0, TI, 0, 0, 32'hDEAD_BEEF,1, 0, 1,  1,  0,  32'hDEAD_BEEF,0);
        v("w_addr",      0, TN, 1, 0, 32'h0,        1, 0, 1,  1,  0,  32'h0,        0);
        v("wait1",       0, TN, 0, 1, 32'h1111,     0, 0, 1,  0,  0,  32'h1111,     0);
        v("wait2",       0, TN, 0, 1, 32'h1111,     0, 0, 1,  0,  0,  32'h1111,     0);
        v("wait3",       0, TN, 0, 1, 32'h1111,     0, 0, 1,  0,  0,  32'h1111,     0);
        v("wait_done",   0, TI, 0, 0, 32'h2222,     1, 0, 1,  1,  0,  32'h2222,     0);
        v("no_capture",  0, TI, 0, 0, 32'h3333,     1, 0, 1,  1,  0,  32'h0,        0);
        v("d_addr",      0, TN, 0, 1, 32'hFFFF,     1, 0, 1,  1,  0,  32'h0,        0);
        v("dflt_err1",   0, TI, 0, 0, 32'hFFFF,     1, 0, 1,  0,  1,  32'h0,        0);
        v("dflt_err2",   0, TI, 0, 0, 32'hFFFF,     1, 0, 1,  1,  1,  32'h0,        0);
        v("dflt_after",  0, TI, 0, 0, 32'hFFFF,     1, 0, 1,  1,  0,  32'h0,        0);
        v("b2b_addr",    0, TN, 0, 1, 32'hFFFF,     1, 0, 1,  1,  0,  32'h0,        0);
        v("b2b_e1a",     0, TN, 0, 1, 32'hFFFF,     1, 0, 1,  0,  1,  32'h0,        0);
        v("b2b_e2a",     0, TN, 0, 1, 32'hFFFF,     1, 0, 1,  1,  1,  32'h0,        0);
        v("b2b_e1b",     0, TI, 0, 0, 32'hFFFF,     1, 0, 1,  0,  1,  32'h0,        0);
        v("b2b_e2b",     0, TI, 0, 0, 32'hFFFF,     1, 0, 1,  1,  1,  32'h0,        0);
        v("b2b_idle",    0, TI, 0, 0, 32'hFFFF,     1, 0, 1,  1,  0,  32'h0,        0);
        v("busy_addr",   0, TB, 1, 0, 32'hABCD,     1, 0, 1,  1,  0,  32'h0,        0);
        v("busy_dp",     0, TI, 0, 1, 32'hABCD,     1, 0, 1,  1,  0,  32'h0,        0);
        v("idle_stale",  0, TI, 0, 0, 32'hABCD,     1, 0, 1,  1,  0,  32'h0,        0);
        v("both_addr",   0, TN, 1, 1, 32'h0,        1, 0, 1,  1,  0,  32'h0,        0);
        v("both_sram",   0, TI, 0, 0, 32'hCAFE,     1, 0, 1,  1,  0,  32'hCAFE,     0);
        v("both_after",  0, TI, 0, 0, 32'hCAFE,     1, 0, 1,  1,  0,  32'h0,        0);
        v("serr_addr",   0, TS, 1, 0, 32'h0,        1, 0, 1,  1,  0,  32'h0,        0);
        v("serr_wait",   0, TI, 0, 0, 32'h0,        0, 1, 1,  0,  1,  32'h0,        0);
        v("serr_done",   0, TI, 0, 0, 32'h0,        1, 1, 1,  1,  1,  32'h0,        0);
        v("serr_after",  0, TI, 0, 0, 32'h0,        1, 0, 1,  1,  0,  32'h0,        0);
        v("rw_addr",     0, TN, 1, 0, 32'h0,        1, 0, 1,  1,  0,  32'h0,        0);
        v("rw_wait",     0, TI, 0, 0, 32'h5555,     0, 0, 1,  0,  0,  32'h5555,     0);
        v("rw_rst_a",    1, TI, 0, 0, 32'h5555,     0, 0, 1,  0,  0,  32'h5555,     0);
        v("rw_rst_b",    1, TI, 0, 0, 32'h5555,     0, 0, 1,  1,  0,  32'h0,        0);
        v("rw_release",  0, TI, 0, 0, 32'h5555,     0, 0, 1,  1,  0,  32'h0,        0);
        v("rd_addr",     0, TN, 0, 1, 32'h0,        1, 0, 1,  1,  0,  32'h0,        0);
        v("rd_rst_e1",   1, TI, 0, 0, 32'h0,        1, 0, 1,  0,  1,  32'h0,        0);
        v("rd_release",  0, TI, 0, 0, 32'h0,        1, 0, 1,  1,  0,  32'h0,        0);
        v("rd_idle",     0, TI, 0, 0, 32'h0,        1, 0, 1,  1,  0,  32'h0,        0);
`ifdef AHB_MUX_TIMEOUT_EN
        v("to_addr",     0, TN, 1, 0, 32'h0,        1, 0, 1,  1,  0,  32'h0,        0);
        v("to_w1",       0, TI, 0, 0, 32'h7777,     0, 0, 1,  0,  0,  32'h7777,     0);
        v("to_w2",       0, TI, 0, 0, 32'h7777,     0, 0, 1,  0,  0,  32'h7777,     0);
        v("to_w3",       0, TI, 0, 0, 32'h7777,     0, 0, 1,  0,  0,  32'h7777,     0);
        v("to_w4",       0, TI, 0, 0, 32'h7777,     0, 0, 1,  0,  0,  32'h7777,     0);
        v("to_err1",     0, TI, 0, 0, 32'h7777,     0, 0, 1,  0,  1,  32'h0,        1);
        v("to_err2",     0, TI, 0, 0, 32'h7777,     0, 0, 1,  1,  1,  32'h0,        0);
        v("to_idle",     0, TI, 0, 0, 32'h7777,     1, 0, 1,  1,  0,  32'h0,        0);
`endif

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
